pipe_mips32_core: RTL and testbench
===================================

// Module: pipe_mips32_core
// PURPOSE
// - 5-stage (IF/ID/EX/MEM/WB) in-order pipelined MIPS32-subset CPU, single clock.
// - Unified word-addressed instruction/data memory internal to the block.
// - Loaded by the bench hierarchically; runs until HLT retires.
// - Full forwarding and a load-use interlock, so dependent instructions need no spacing.
// PARAMETERS
// - MEM_WORDS  1024  depth of unified memory Mem, 32-bit words
// PORTS
// - clk     input   1  single clock, rising edge
// - rst     input   1  asynchronous, active-high reset
// - halted  output  1  mirrors HALTED
// BEHAVIOUR
// - Hierarchical state, names fixed for benches:
//   - Reg[0:31] (32b)
//   - Mem[0:MEM_WORDS-1] (32b)
//   - PC (32b word address)
//   - HALTED (1b)
//   - TAKEN_BRANCH (1b)
// - Reset: PC=0, HALTED=0, TAKEN_BRANCH=0, all pipeline registers become bubbles.
//   - Reg and Mem are not reset.
//   - Reset mid-run aborts in-flight instructions with no writes; restart at PC 0.
// - Encoding:
//   - opcode [31:26], rs [25:21], rt [20:16], rd [15:11].
//   - imm [15:0], sign-extended to 32 bits.
// - Opcodes, register-register class (writes rd):
//   - ADD 000000, SUB 000001, AND 000010, OR 000011.
//   - SLT 000100: signed, result 1/0.
//   - MUL 000101: low 32 bits of the product.
// - Opcodes, register-immediate class (writes rt):
//   - LW 001000, ADDI 001010, SUBI 001011.
//   - SLTI 001100: signed.
// - Other opcodes:
//   - SW 001001: Mem[rs+imm] = Reg[rt].
//   - BNEQZ 001101, BEQZ 001110: test Reg[rs].
//   - HLT 111111.
//   - Any other opcode executes as a NOP.
// - Arithmetic: 32-bit wrap-around, no overflow traps.
// - Memory address = (Reg[rs]+imm) truncated to log2(MEM_WORDS) bits.
// - Writes to R0 are discarded; R0 always reads 0.
// - IF reads Mem[PC]; NPC = PC+1.
// - ID register reads are write-first: a same-cycle WB write is visible.
// - EX forwarding priority: EX/MEM result, then MEM/WB result, then ID value.
//   - Applies to rs, rt and SW store data.
// - Load-use: consumer directly behind an LW stalls 1 cycle (PC and IF/ID hold, bubble into EX).
// - Branches resolve in EX; target = branch NPC + imm.
//   - Taken: PC=target next edge, IF/ID and ID/EX flushed to bubbles (2-cycle penalty).
//   - TAKEN_BRANCH pulses high for that one cycle. Not-taken: no penalty.
// - MEM stage: LW reads Mem, SW writes Mem; a store is visible to IF one cycle later.
// - HLT decoded in ID stops fetch; younger slots are bubbles.
// - Older instructions complete; HALTED=1 on the edge HLT is in WB.
// - Once HALTED: PC, Reg, Mem frozen until rst.
// STRUCTURE
// - Shared package pipe_mips32_pkg: opcode localparams, instruction-class enum
//   (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP), field-slice constants.
// - One sub-module pipe_mips32_alu:
//   - inputs: opcode and two 32b operands; output: 32b result (combinational).
// - Pipeline registers, forwarding, hazard and memory logic stay in the top.
// TESTING
// - Load program, Mem[120]=85, Reg[k]=k, pulse rst:
//   - Program: ADDI R1,R0,120; OR R3,R3,R3; LW R2,0(R1); OR; ADDI R2,R2,45; OR; SW R2,1(R1); HLT.
//   - Expect: Mem[121]=130, Mem[120]=85, halted=1.
// - Same program with the ORs removed (back-to-back dependences):
//   - Expect: Mem[121]=130; exactly one load-use stall cycle.
// - Reg[k]=k, run ADD/SUB/AND/OR/SLT/MUL R5,R7,R9 and SUB R5,R7,R9:
//   - Expect: 16, 7&9=1, 7|9=15, SLT=1, MUL=63.
//   - Expect SUB gives 32'hFFFFFFFE.
// - Factorial loop with BNEQZ back-branch on counter 5:
//   - Expect: result 120.
//   - Expect: TAKEN_BRANCH pulses 4 times; instructions after a taken branch never write.
// - ADDI R0,R0,7 then SW R0,0(R0) with R10 at address:
//   - Expect: Reg[0] stays 0; stored word 0.
// - Assert rst mid-loop:
//   - Expect: PC=0, halted=0 asynchronously; no further Mem/Reg writes while rst=1.

Source files
------------

// File: rtl/pipe_mips32_pkg.sv
// Shared opcodes, instruction-class enum and field positions for the pipelined MIPS32 core.
package pipe_mips32_pkg;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 26;
   localparam int unsigned RS_MSB  = 25;
   localparam int unsigned RS_LSB  = 21;
   localparam int unsigned RT_MSB  = 20;
   localparam int unsigned RT_LSB  = 16;
   localparam int unsigned RD_MSB  = 15;
   localparam int unsigned RD_LSB  = 11;
   localparam int unsigned IMM_MSB = 15;

   typedef enum logic [2:0] {
      RR_ALU,
      RM_ALU,
      LOAD,
      STORE,
      BRANCH,
      HALT,
      NOP
   } instr_class_t;

   function automatic instr_class_t decode_class(input logic [5:0] op);
      instr_class_t cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: cls = RR_ALU;
         OP_ADDI, OP_SUBI, OP_SLTI:                     cls = RM_ALU;
         OP_LW:                                         cls = LOAD;
         OP_SW:                                         cls = STORE;
         OP_BNEQZ, OP_BEQZ:                             cls = BRANCH;
         OP_HLT:                                        cls = HALT;
         default:                                       cls = NOP;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/pipe_mips32_alu.sv
// Combinational ALU; loads and stores use the add path for address generation.
module pipe_mips32_alu
   import pipe_mips32_pkg::*;
(
   input  logic [5:0]  opcode,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result
);

   always_comb begin
      result = 32'd0;
      case (opcode)
         OP_ADD, OP_ADDI, OP_LW, OP_SW: result = a + b;
         OP_SUB, OP_SUBI:               result = a - b;
         OP_AND:                        result = a & b;
         OP_OR:                         result = a | b;
         OP_SLT, OP_SLTI:               result = {31'd0, $signed(a) < $signed(b)};
         OP_MUL:                        result = a * b;
         default:                       result = 32'd0;
      endcase
   end

endmodule

// File: rtl/pipe_mips32_core.sv
// 5-stage in-order MIPS32-subset core with unified word memory, full forwarding and
// a one-cycle load-use interlock.
module pipe_mips32_core
   import pipe_mips32_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic clk,
   input  logic rst,
   output logic halted
);

   localparam int unsigned AW = $clog2(MEM_WORDS);

   logic [31:0] Reg [0:31];
   logic [31:0] Mem [0:MEM_WORDS-1];
   logic [31:0] PC;
   logic        HALTED;
   logic        TAKEN_BRANCH;
   logic        halt_pend;

   logic         if_id_valid;
   logic [31:0]  if_id_ir, if_id_npc;

   instr_class_t id_ex_class;
   logic [5:0]   id_ex_op;
   logic [4:0]   id_ex_rs, id_ex_rt, id_ex_dst;
   logic [31:0]  id_ex_a, id_ex_b, id_ex_imm, id_ex_npc;

   instr_class_t ex_mem_class;
   logic [4:0]   ex_mem_dst;
   logic [31:0]  ex_mem_alu, ex_mem_b;

   instr_class_t mem_wb_class;
   logic [4:0]   mem_wb_dst;
   logic [31:0]  mem_wb_result;

   logic [5:0]   id_op;
   logic [4:0]   id_rs, id_rt, id_rd, id_dst;
   logic [31:0]  id_imm, id_a, id_b;
   instr_class_t id_class;
   logic         id_uses_rs, id_uses_rt, load_use, fetch_stop;

   logic [31:0]  fwd_a, fwd_b, alu_b, alu_out, branch_target, mem_result;
   logic         branch_taken;

   assign halted = HALTED;

   assign id_op  = if_id_ir[OPC_MSB:OPC_LSB];
   assign id_rs  = if_id_ir[RS_MSB:RS_LSB];
   assign id_rt  = if_id_ir[RT_MSB:RT_LSB];
   assign id_rd  = if_id_ir[RD_MSB:RD_LSB];
   assign id_imm = {{16{if_id_ir[IMM_MSB]}}, if_id_ir[IMM_MSB:0]};

   // A destination of 0 doubles as "no register write", so R0 is never written or forwarded.
   always_comb begin
      id_class   = if_id_valid ? decode_class(id_op) : NOP;
      id_uses_rs = id_class inside {RR_ALU, RM_ALU, LOAD, STORE, BRANCH};
      id_uses_rt = id_class inside {RR_ALU, STORE};
      case (id_class)
         RR_ALU:       id_dst = id_rd;
         RM_ALU, LOAD: id_dst = id_rt;
         default:      id_dst = 5'd0;
      endcase
      if (id_rs == 5'd0)                                  id_a = 32'd0;
      else if (mem_wb_dst != 5'd0 && mem_wb_dst == id_rs) id_a = mem_wb_result;
      else                                                id_a = Reg[id_rs];
      if (id_rt == 5'd0)                                  id_b = 32'd0;
      else if (mem_wb_dst != 5'd0 && mem_wb_dst == id_rt) id_b = mem_wb_result;
      else                                                id_b = Reg[id_rt];
   end

   assign load_use = (id_ex_class == LOAD) && (id_ex_dst != 5'd0) &&
                     ((id_uses_rs && id_rs == id_ex_dst) || (id_uses_rt && id_rt == id_ex_dst));

   always_comb begin
      if (ex_mem_dst != 5'd0 && ex_mem_dst == id_ex_rs)      fwd_a = ex_mem_alu;
      else if (mem_wb_dst != 5'd0 && mem_wb_dst == id_ex_rs) fwd_a = mem_wb_result;
      else                                                   fwd_a = id_ex_a;
      if (ex_mem_dst != 5'd0 && ex_mem_dst == id_ex_rt)      fwd_b = ex_mem_alu;
      else if (mem_wb_dst != 5'd0 && mem_wb_dst == id_ex_rt) fwd_b = mem_wb_result;
      else                                                   fwd_b = id_ex_b;
      alu_b = (id_ex_class == RR_ALU) ? fwd_b : id_ex_imm;
   end

   pipe_mips32_alu u_alu (
      .opcode (id_ex_op),
      .a      (fwd_a),
      .b      (alu_b),
      .result (alu_out)
   );

   assign branch_taken  = (id_ex_class == BRANCH) && ((id_ex_op == OP_BEQZ) == (fwd_a == 32'd0));
   assign branch_target = id_ex_npc + id_ex_imm;
   assign mem_result    = (ex_mem_class == LOAD) ? Mem[ex_mem_alu[AW-1:0]] : ex_mem_alu;
   // A HLT in ID squashed by an older taken branch must not stop fetch.
   assign fetch_stop    = HALTED || halt_pend || (id_class == HALT && !branch_taken);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PC            <= 32'd0;
         HALTED        <= 1'b0;
         TAKEN_BRANCH  <= 1'b0;
         halt_pend     <= 1'b0;
         if_id_valid   <= 1'b0;
         if_id_ir      <= 32'd0;
         if_id_npc     <= 32'd0;
         id_ex_class   <= NOP;
         id_ex_op      <= 6'd0;
         id_ex_rs      <= 5'd0;
         id_ex_rt      <= 5'd0;
         id_ex_dst     <= 5'd0;
         id_ex_a       <= 32'd0;
         id_ex_b       <= 32'd0;
         id_ex_imm     <= 32'd0;
         id_ex_npc     <= 32'd0;
         ex_mem_class  <= NOP;
         ex_mem_dst    <= 5'd0;
         ex_mem_alu    <= 32'd0;
         ex_mem_b      <= 32'd0;
         mem_wb_class  <= NOP;
         mem_wb_dst    <= 5'd0;
         mem_wb_result <= 32'd0;
      end else if (!HALTED) begin
         TAKEN_BRANCH  <= branch_taken;
         HALTED        <= (mem_wb_class == HALT);
         halt_pend     <= halt_pend || (id_class == HALT && !branch_taken);
         ex_mem_class  <= id_ex_class;
         ex_mem_dst    <= id_ex_dst;
         ex_mem_alu    <= alu_out;
         ex_mem_b      <= fwd_b;
         mem_wb_class  <= ex_mem_class;
         mem_wb_dst    <= ex_mem_dst;
         mem_wb_result <= mem_result;
         if (branch_taken) begin
            PC          <= branch_target;
            if_id_valid <= 1'b0;
            id_ex_class <= NOP;
            id_ex_dst   <= 5'd0;
         end else if (load_use) begin
            id_ex_class <= NOP;
            id_ex_dst   <= 5'd0;
         end else begin
            id_ex_class <= id_class;
            id_ex_op    <= id_op;
            id_ex_rs    <= id_rs;
            id_ex_rt    <= id_rt;
            id_ex_dst   <= id_dst;
            id_ex_a     <= id_a;
            id_ex_b     <= id_b;
            id_ex_imm   <= id_imm;
            id_ex_npc   <= if_id_npc;
            if (fetch_stop) begin
               if_id_valid <= 1'b0;
            end else begin
               if_id_valid <= 1'b1;
               if_id_ir    <= Mem[PC[AW-1:0]];
               if_id_npc   <= PC + 32'd1;
               PC          <= PC + 32'd1;
            end
         end
      end
   end

   // Architectural storage is not reset; writes are suppressed while rst is held.
   always_ff @(posedge clk) begin
      if (!rst && !HALTED) begin
         if (mem_wb_dst != 5'd0)      Reg[mem_wb_dst] <= mem_wb_result;
         if (ex_mem_class == STORE)   Mem[ex_mem_alu[AW-1:0]] <= ex_mem_b;
      end
   end

endmodule

// File: tb/tb_pipe_mips32_core.sv
// Directed bench for pipe_mips32_core: programs are loaded hierarchically and results
// checked against hand-computed values.
module tb_pipe_mips32_core;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic halted;
   int   n_checks = 0;
   int   n_fail   = 0;

   localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011;
   localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001;
   localparam logic [5:0] ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100;
   localparam logic [5:0] BNEQZ = 6'b001101;
   localparam logic [31:0] HLT = 32'hFC00_0000;

   pipe_mips32_core #(.MEM_WORDS(1024)) dut (
      .clk    (clk),
      .rst    (rst),
      .halted (halted)
   );

   always #5 clk = ~clk;

   logic [31:0] prog [$];

   function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs,
                                      input int rt);
      return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs,
                                      input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   task automatic load_prog();
      rst = 1'b1;
      #1;
      for (int k = 0; k < 32; k++) dut.Reg[k] = k;
      for (int i = 0; i < 256; i++) dut.Mem[i] = 32'd0;
      foreach (prog[i]) dut.Mem[i] = prog[i];
   endtask

   task automatic go();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_to_halt(output int cycles, output int taken);
      cycles = 0;
      taken  = 0;
      while (!halted && cycles < 500) begin
         @(posedge clk);
         #1;
         cycles++;
         if (dut.TAKEN_BRANCH) taken++;
      end
      n_checks++;
      if (halted !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_timeout: halted=%b required 1 after %0d cycles", halted, cycles);
      end
   endtask

   task automatic test_spaced_load_store();
      int cyc, tk;
      prog = '{ri(ADDI, 1, 0, 16'd120), rr(OR_, 3, 3, 3), ri(LW, 2, 1, 16'd0), rr(OR_, 3, 3, 3),
               ri(ADDI, 2, 2, 16'd45), rr(OR_, 3, 3, 3), ri(SW, 2, 1, 16'd1), HLT};
      load_prog();
      dut.Mem[120] = 32'd85;
      go();
      run_to_halt(cyc, tk);
      n_checks++;
      if (dut.Mem[121] !== 32'd130) begin
         n_fail++; $display("FAIL spaced_mem121: got %0d required 130", dut.Mem[121]);
      end
      n_checks++;
      if (dut.Mem[120] !== 32'd85) begin
         n_fail++; $display("FAIL spaced_mem120: got %0d required 85", dut.Mem[120]);
      end
      n_checks++;
      if (cyc != 12) begin
         n_fail++; $display("FAIL spaced_cycles: got %0d required 12", cyc);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (dut.PC !== 32'd8 || halted !== 1'b1) begin
         n_fail++; $display("FAIL spaced_frozen: PC=%0d halted=%b required PC=8 halted=1",
                            dut.PC, halted);
      end
   endtask

   task automatic test_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      n_checks++;
      if (halted !== 1'b0 || dut.PC !== 32'd0 || dut.TAKEN_BRANCH !== 1'b0) begin
         n_fail++; $display("FAIL reset_state: halted=%b PC=%0d taken=%b required 0/0/0",
                            halted, dut.PC, dut.TAKEN_BRANCH);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, tk;
      prog = '{ri(ADDI, 1, 0, 16'd120), ri(LW, 2, 1, 16'd0), ri(ADDI, 2, 2, 16'd45),
               ri(SW, 2, 1, 16'd1), HLT};
      load_prog();
      dut.Mem[120] = 32'd85;
      go();
      run_to_halt(cyc, tk);
      n_checks++;
      if (dut.Mem[121] !== 32'd130) begin
         n_fail++; $display("FAIL b2b_mem121: got %0d required 130", dut.Mem[121]);
      end
      n_checks++;
      if (cyc != 10) begin
         n_fail++; $display("FAIL b2b_cycles (one load-use stall): got %0d required 10", cyc);
      end
      n_checks++;
      if (dut.Reg[1] !== 32'd120) begin
         n_fail++; $display("FAIL b2b_r1: got %0d required 120", dut.Reg[1]);
      end
   endtask

   task automatic test_alu_ops();
      int cyc, tk;
      int dst [9] = '{11, 12, 13, 14, 15, 16, 17, 18, 19};
      logic [31:0] exp [9] = '{32'd16, 32'hFFFF_FFFE, 32'd1, 32'd15, 32'd1, 32'd63,
                               32'hFFFF_FFFD, 32'd1, 32'd0};
      prog = '{rr(ADD, 11, 7, 9), rr(SUB, 12, 7, 9), rr(AND_, 13, 7, 9), rr(OR_, 14, 7, 9),
               rr(SLT, 15, 7, 9), rr(MUL, 16, 7, 9), ri(SUBI, 17, 7, 16'd10),
               ri(SLTI, 18, 17, 16'hFFFF), rr(SLT, 19, 9, 7), HLT};
      load_prog();
      go();
      run_to_halt(cyc, tk);
      for (int i = 0; i < 9; i++) begin
         n_checks++;
         if (dut.Reg[dst[i]] !== exp[i]) begin
            n_fail++; $display("FAIL alu_r%0d: got %h required %h", dst[i], dut.Reg[dst[i]],
                               exp[i]);
         end
      end
   endtask

   task automatic load_factorial();
      prog = '{ri(ADDI, 1, 0, 16'd5), ri(ADDI, 2, 0, 16'd1), rr(MUL, 2, 2, 1),
               ri(SUBI, 1, 1, 16'd1), ri(BNEQZ, 0, 1, 16'hFFFD), ri(ADDI, 21, 21, 16'd1),
               ri(ADDI, 22, 22, 16'd1), HLT};
      load_prog();
   endtask

   task automatic test_factorial();
      int cyc, tk;
      load_factorial();
      go();
      run_to_halt(cyc, tk);
      n_checks++;
      if (dut.Reg[2] !== 32'd120) begin
         n_fail++; $display("FAIL fact_result: got %0d required 120", dut.Reg[2]);
      end
      n_checks++;
      if (tk != 4) begin
         n_fail++; $display("FAIL fact_taken_pulses: got %0d required 4", tk);
      end
      n_checks++;
      if (dut.Reg[21] !== 32'd22 || dut.Reg[22] !== 32'd23) begin
         n_fail++; $display("FAIL fact_shadow_writes: r21=%0d r22=%0d required 22/23",
                            dut.Reg[21], dut.Reg[22]);
      end
      n_checks++;
      if (dut.Reg[1] !== 32'd0) begin
         n_fail++; $display("FAIL fact_counter: got %0d required 0", dut.Reg[1]);
      end
   endtask

   task automatic test_r0();
      int cyc, tk;
      prog = '{ri(ADDI, 0, 0, 16'd7), ri(SW, 0, 10, 16'd0), HLT};
      load_prog();
      dut.Mem[10] = 32'hDEAD_BEEF;
      go();
      run_to_halt(cyc, tk);
      n_checks++;
      if (dut.Reg[0] !== 32'd0) begin
         n_fail++; $display("FAIL r0_reg: got %0d required 0", dut.Reg[0]);
      end
      n_checks++;
      if (dut.Mem[10] !== 32'd0) begin
         n_fail++; $display("FAIL r0_store: got %h required 0", dut.Mem[10]);
      end
   endtask

   task automatic test_reset_mid_run();
      int cyc, tk;
      logic [31:0] r1, r2, r21;
      load_factorial();
      go();
      repeat (9) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (dut.PC !== 32'd0 || halted !== 1'b0) begin
         n_fail++; $display("FAIL midrst_async: PC=%0d halted=%b required 0/0", dut.PC, halted);
      end
      r1  = dut.Reg[1];
      r2  = dut.Reg[2];
      r21 = dut.Reg[21];
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (dut.Reg[1] !== r1 || dut.Reg[2] !== r2 || dut.Reg[21] !== r21 || dut.PC !== 32'd0) begin
         n_fail++; $display("FAIL midrst_frozen: r1=%0d r2=%0d r21=%0d PC=%0d required %0d/%0d/%0d/0",
                            dut.Reg[1], dut.Reg[2], dut.Reg[21], dut.PC, r1, r2, r21);
      end
      go();
      run_to_halt(cyc, tk);
      n_checks++;
      if (dut.Reg[2] !== 32'd120 || tk != 4) begin
         n_fail++; $display("FAIL midrst_restart: r2=%0d taken=%0d required 120/4",
                            dut.Reg[2], tk);
      end
   endtask

   initial begin
      test_spaced_load_store();
      test_reset();
      test_back_to_back();
      test_alu_ops();
      test_factorial();
      test_r0();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
